// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeping core: mode FSM encoding and
// one-hot edit-cursor constants consumed by the display mux.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } state_t;

    localparam logic [2:0] CUR_NONE = 3'b000;
    localparam logic [2:0] CUR_SEC  = 3'b001;
    localparam logic [2:0] CUR_MIN  = 3'b010;
    localparam logic [2:0] CUR_HOUR = 3'b100;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX field counter with synchronous clear, up/down step and a
// combinational carry that fires when an increment wraps MAX-1 -> 0.
module wrap_counter #(
    parameter int unsigned MAX = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    clr,
    output logic [$clog2(MAX)-1:0]  value,
    output logic                    carry_out
);

    localparam int unsigned W = $clog2(MAX);
    localparam logic [W-1:0] TOP = W'(MAX - 1);

    assign carry_out = inc && (value == TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (dec) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/watch_time_core.sv
// Timekeeping core: centisecond prescaler, rippling time fields, run/set FSM
// with rotating cursor, inc/dec with hold-to-repeat and cursor blink timer.
module watch_time_core
    import watch_pkg::*;
#(
    parameter int unsigned COUNT_TICK   = 1_000_000,
    parameter int unsigned MSEC_MAX     = 100,
    parameter int unsigned SEC_MAX      = 60,
    parameter int unsigned MIN_MAX      = 60,
    parameter int unsigned HOUR_MAX     = 24,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned BLINK_HALF   = 25_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set_sw,
    input  logic                         btn_sel,
    input  logic                         btn_inc,
    input  logic                         btn_dec,
    output logic [$clog2(MSEC_MAX)-1:0]  msec,
    output logic [$clog2(SEC_MAX)-1:0]   sec,
    output logic [$clog2(MIN_MAX)-1:0]   min,
    output logic [$clog2(HOUR_MAX)-1:0]  hour,
    output logic [2:0]                   cursor,
    output logic                         blink
);

    localparam int unsigned PW = $clog2(COUNT_TICK);
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF);

    state_t          state, state_next;
    logic            sel_q, inc_q, dec_q;
    logic [PW-1:0]   presc;
    logic [RW-1:0]   rep_cnt;
    logic [BW-1:0]   blink_cnt;

    logic in_set, editing, sel_rise, one_btn, btn_rise, rep_fire;
    logic step, step_inc, step_dec, cursor_move, tick;
    logic msec_c, sec_c, min_c, hour_carry_unused;

    assign in_set      = (state != RUN);
    assign editing     = in_set && set_sw;
    assign sel_rise    = btn_sel && !sel_q;
    assign one_btn     = btn_inc ^ btn_dec;
    assign btn_rise    = (btn_inc && !inc_q) || (btn_dec && !dec_q);
    assign rep_fire    = (rep_cnt == RW'(REPEAT_DELAY));
    assign cursor_move = editing && sel_rise;
    // A cursor move wins over a coincident step; both-pressed never steps.
    assign step        = editing && one_btn && (btn_rise || rep_fire) && !sel_rise;
    assign step_inc    = step && btn_inc;
    assign step_dec    = step && btn_dec;
    assign tick        = (state == RUN) && (presc == PW'(COUNT_TICK - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RUN: if (set_sw) state_next = SET_SEC;
            SET_SEC:  if (!set_sw) state_next = RUN; else if (sel_rise) state_next = SET_MIN;
            SET_MIN:  if (!set_sw) state_next = RUN; else if (sel_rise) state_next = SET_HOUR;
            SET_HOUR: if (!set_sw) state_next = RUN; else if (sel_rise) state_next = SET_SEC;
            default:  state_next = RUN;
        endcase
    end

    // Output decode of the state register
    always_comb begin
        cursor = CUR_NONE;
        case (state)
            SET_SEC:  cursor = CUR_SEC;
            SET_MIN:  cursor = CUR_MIN;
            SET_HOUR: cursor = CUR_HOUR;
            default:  cursor = CUR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= 1'b0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            sel_q <= btn_sel;
            inc_q <= btn_inc;
            dec_q <= btn_dec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      presc <= '0;
        else if (in_set) presc <= '0;
        else if (tick)   presc <= '0;
        else             presc <= presc + 1'b1;
    end

    // Repeat counter is idle at 0; it only starts on a fresh single-button edge,
    // then reloads so that REPEAT_RATE cycles later it hits REPEAT_DELAY again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    rep_cnt <= '0;
        else if (!editing || !one_btn) rep_cnt <= '0;
        else if (btn_rise)             rep_cnt <= RW'(1);
        else if (rep_fire)             rep_cnt <= RW'(REPEAT_DELAY - REPEAT_RATE + 1);
        else if (rep_cnt != '0)        rep_cnt <= rep_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (state_next == RUN || state == RUN || step || cursor_move) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink     <= !blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    wrap_counter #(.MAX(MSEC_MAX)) u_msec (
        .clk(clk), .reset(reset),
        .inc(tick), .dec(1'b0), .clr(in_set),
        .value(msec), .carry_out(msec_c)
    );

    wrap_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .reset(reset),
        .inc(msec_c || (step_inc && state == SET_SEC)),
        .dec(step_dec && state == SET_SEC), .clr(1'b0),
        .value(sec), .carry_out(sec_c)
    );

    wrap_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .reset(reset),
        .inc((sec_c && !in_set) || (step_inc && state == SET_MIN)),
        .dec(step_dec && state == SET_MIN), .clr(1'b0),
        .value(min), .carry_out(min_c)
    );

    wrap_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk), .reset(reset),
        .inc((min_c && !in_set) || (step_inc && state == SET_HOUR)),
        .dec(step_dec && state == SET_HOUR), .clr(1'b0),
        .value(hour), .carry_out(hour_carry_unused)
    );

endmodule

// File: tb/tb_watch_time_core.sv
// Directed bench for watch_time_core with short tick/repeat/blink periods.
module tb_watch_time_core;

    logic       clk;
    logic       reset;
    logic       set_sw, btn_sel, btn_inc, btn_dec;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [2:0] cursor;
    logic       blink;
    logic [23:0] now_t;

    int errors = 0;
    int checks = 0;

    assign now_t = {hour, min, sec, msec};

    watch_time_core #(
        .COUNT_TICK(4), .MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24),
        .REPEAT_DELAY(8), .REPEAT_RATE(2), .BLINK_HALF(6)
    ) dut (
        .clk(clk), .reset(reset), .set_sw(set_sw),
        .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .cursor(cursor), .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] tm(input int h, input int m, input int s, input int c);
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = sel, 1 = inc, 2 = dec; one-cycle pulse then one idle cycle
    task automatic press(input int which);
        case (which)
            0: btn_sel = 1'b1;
            1: btn_inc = 1'b1;
            default: btn_dec = 1'b1;
        endcase
        tick();
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; set_sw = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (3) tick();
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL reset_time got %h want %h", now_t, tm(0,0,0,0)); end
        checks++; if (cursor !== 3'b000) begin errors++; $display("FAIL reset_cursor got %b want 000", cursor); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL reset_blink got %b want 1", blink); end
        reset = 1'b1;
    endtask

    task automatic test_run();
        repeat (399) tick();
        checks++; if (now_t !== tm(0,0,0,99)) begin errors++; $display("FAIL run_399 got %h want %h", now_t, tm(0,0,0,99)); end
        tick();
        checks++; if (now_t !== tm(0,0,1,0)) begin errors++; $display("FAIL run_400 got %h want %h", now_t, tm(0,0,1,0)); end
    endtask

    task automatic test_rollover();
        set_sw = 1'b1;
        tick();
        checks++; if (cursor !== 3'b001) begin errors++; $display("FAIL set_entry_cursor got %b want 001", cursor); end
        press(2);
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL dec_to_zero got %h want %h", now_t, tm(0,0,0,0)); end
        press(2);
        checks++; if (now_t !== tm(0,0,59,0)) begin errors++; $display("FAIL dec_wrap_sec got %h want %h", now_t, tm(0,0,59,0)); end
        checks++; if (cursor !== 3'b001) begin errors++; $display("FAIL dec_wrap_cursor got %b want 001", cursor); end
        press(0);
        press(2);
        press(0);
        press(2);
        checks++; if (now_t !== tm(23,59,59,0)) begin errors++; $display("FAIL preload got %h want %h", now_t, tm(23,59,59,0)); end
        set_sw = 1'b0;
        tick();
        checks++; if (cursor !== 3'b000) begin errors++; $display("FAIL exit_cursor got %b want 000", cursor); end
        repeat (396) tick();
        checks++; if (now_t !== tm(23,59,59,99)) begin errors++; $display("FAIL pre_rollover got %h want %h", now_t, tm(23,59,59,99)); end
        repeat (4) tick();
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL day_rollover got %h want %h", now_t, tm(0,0,0,0)); end
    endtask

    task automatic test_blink_cursor();
        set_sw = 1'b1;
        tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_entry got %b want 1", blink); end
        repeat (5) tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_hold got %b want 1", blink); end
        tick();
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_off got %b want 0", blink); end
        repeat (5) tick();
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_off_hold got %b want 0", blink); end
        tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_on got %b want 1", blink); end
        press(0);
        checks++; if (cursor !== 3'b010) begin errors++; $display("FAIL cursor_min got %b want 010", cursor); end
        press(0);
        checks++; if (cursor !== 3'b100) begin errors++; $display("FAIL cursor_hour got %b want 100", cursor); end
        press(0);
        checks++; if (cursor !== 3'b001) begin errors++; $display("FAIL cursor_sec got %b want 001", cursor); end
    endtask

    task automatic test_repeat();
        press(0);
        press(2);
        press(2);
        checks++; if (now_t !== tm(0,58,0,0)) begin errors++; $display("FAIL min_58 got %h want %h", now_t, tm(0,58,0,0)); end
        btn_inc = 1'b1;
        tick();
        checks++; if (now_t !== tm(0,59,0,0)) begin errors++; $display("FAIL rep_first got %h want %h", now_t, tm(0,59,0,0)); end
        repeat (7) tick();
        checks++; if (now_t !== tm(0,59,0,0)) begin errors++; $display("FAIL rep_delay got %h want %h", now_t, tm(0,59,0,0)); end
        tick();
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL rep_wrap_nocarry got %h want %h", now_t, tm(0,0,0,0)); end
        repeat (11) tick();
        checks++; if (now_t !== tm(0,5,0,0)) begin errors++; $display("FAIL rep_held20 got %h want %h", now_t, tm(0,5,0,0)); end
        btn_inc = 1'b0;
        tick();
        checks++; if (now_t !== tm(0,5,0,0)) begin errors++; $display("FAIL rep_release got %h want %h", now_t, tm(0,5,0,0)); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_after_edit got %b want 1", blink); end
    endtask

    task automatic test_conflict();
        btn_inc = 1'b1; btn_dec = 1'b1;
        repeat (12) tick();
        checks++; if (now_t !== tm(0,5,0,0)) begin errors++; $display("FAIL both_held got %h want %h", now_t, tm(0,5,0,0)); end
        btn_inc = 1'b0; btn_dec = 1'b0;
        tick();
        btn_sel = 1'b1; btn_inc = 1'b1;
        tick();
        checks++; if (cursor !== 3'b100) begin errors++; $display("FAIL sel_inc_cursor got %b want 100", cursor); end
        checks++; if (now_t !== tm(0,5,0,0)) begin errors++; $display("FAIL sel_inc_field got %h want %h", now_t, tm(0,5,0,0)); end
        btn_sel = 1'b0; btn_inc = 1'b0;
        tick();
        checks++; if (now_t !== tm(0,5,0,0)) begin errors++; $display("FAIL sel_inc_after got %h want %h", now_t, tm(0,5,0,0)); end
    endtask

    task automatic test_exit();
        for (int i = 0; i < 12; i++) press(1);
        press(0);
        for (int i = 0; i < 4; i++) press(2);
        press(0);
        for (int i = 0; i < 29; i++) press(1);
        checks++; if (now_t !== tm(12,34,56,0)) begin errors++; $display("FAIL set_12_34_56 got %h want %h", now_t, tm(12,34,56,0)); end
        set_sw = 1'b0;
        tick();
        checks++; if (cursor !== 3'b000) begin errors++; $display("FAIL exit2_cursor got %b want 000", cursor); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL run_blink got %b want 1", blink); end
        repeat (3) tick();
        checks++; if (now_t !== tm(12,34,56,0)) begin errors++; $display("FAIL exit_before_tick got %h want %h", now_t, tm(12,34,56,0)); end
        tick();
        checks++; if (now_t !== tm(12,34,56,1)) begin errors++; $display("FAIL exit_first_tick got %h want %h", now_t, tm(12,34,56,1)); end
    endtask

    task automatic test_reset_mid_repeat();
        set_sw = 1'b1;
        tick();
        btn_inc = 1'b1;
        tick();
        checks++; if (now_t !== tm(12,34,57,0)) begin errors++; $display("FAIL mid_first got %h want %h", now_t, tm(12,34,57,0)); end
        repeat (8) tick();
        checks++; if (now_t !== tm(12,34,58,0)) begin errors++; $display("FAIL mid_repeat got %h want %h", now_t, tm(12,34,58,0)); end
        #2 reset = 1'b0;
        #1;
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL async_time got %h want %h", now_t, tm(0,0,0,0)); end
        checks++; if (cursor !== 3'b000) begin errors++; $display("FAIL async_cursor got %b want 000", cursor); end
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL async_blink got %b want 1", blink); end
        tick();
        reset = 1'b1;
        repeat (15) tick();
        checks++; if (now_t !== tm(0,0,0,0)) begin errors++; $display("FAIL post_reset_steps got %h want %h", now_t, tm(0,0,0,0)); end
        checks++; if (cursor !== 3'b001) begin errors++; $display("FAIL post_reset_cursor got %b want 001", cursor); end
        btn_inc = 1'b0; set_sw = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_run();
        test_rollover();
        test_blink_cursor();
        test_repeat();
        test_conflict();
        test_exit();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_time_core.md
# watch_time_core

Parametrised timekeeping core that succeeds the fixed sec/min/hour watch controller: one block holds the time counters, a run/set mode FSM with a rotating edit cursor, and increment/decrement with hold-to-repeat. It sits between the `btn_debounce` instances, which supply debounced button levels, and the FND display mux, which consumes the field values plus a cursor and blink indication.

## Interface
- `COUNT_TICK`, 1_000_000: clk cycles per 1/100 s tick
- `MSEC_MAX`, 100: centisecond modulus
- `SEC_MAX`, 60: seconds modulus
- `MIN_MAX`, 60: minutes modulus
- `HOUR_MAX`, 24: hours modulus
- `REPEAT_DELAY`, 50_000_000: held cycles before the first auto-repeat step
- `REPEAT_RATE`, 10_000_000: cycles between auto-repeat steps
- `BLINK_HALF`, 25_000_000: cycles per blink half-period
- `clk` in 1: single system clock
- `reset` in 1: asynchronous, active-low; asserted when 0
- `set_sw` in 1: level; 1 = set mode, 0 = run mode
- `btn_sel` in 1: debounced level; rising edge advances the cursor
- `btn_inc` in 1: debounced level; increments the selected field
- `btn_dec` in 1: debounced level; decrements the selected field
- `msec` out `$clog2(MSEC_MAX)`: centiseconds
- `sec` out `$clog2(SEC_MAX)`: seconds
- `min` out `$clog2(MIN_MAX)`: minutes
- `hour` out `$clog2(HOUR_MAX)`: hours
- `cursor` out 3: one-hot {hour,min,sec}; 000 in run mode
- `blink` out 1: display enable for the cursor field

## Operation
- FSM states: RUN, SET_SEC, SET_MIN, SET_HOUR.
- RUN with `set_sw`=1 goes to SET_SEC.
- In any SET state, `set_sw`=0 returns to RUN.
- A `btn_sel` rising edge in SET rotates the cursor SEC→MIN→HOUR→SEC.
- RUN:
  - Prescaler counts 0..COUNT_TICK-1.
  - On the terminal count, `msec` increments.
  - Carry ripples msec→sec→min→hour in the same cycle.
  - Each field wraps to 0 at its MAX-1. `hour` wraps 23→0 with no further carry.
- SET:
  - Prescaler and `msec` are held at 0.
  - Increment: MAX-1→0. Decrement: 0→MAX-1.
  - Edits never carry into the adjacent field.
- Edge detection uses a registered previous value of each button.
- Auto-repeat:
  - A rising edge of `btn_inc` (or `btn_dec`) causes one step immediately.
  - If held, a further step after REPEAT_DELAY cycles, then one step every REPEAT_RATE cycles until release.
  - Release clears the repeat counter.
- Conflicts:
  - `btn_inc` and `btn_dec` both high: no step, and the repeat counter is cleared.
  - A `btn_sel` edge in the same cycle as a step: cursor moves, step suppressed.
- Buttons are ignored in RUN; no edits and no repeat counting.
- Leaving SET: prescaler and `msec` restart from 0, so the first run tick arrives COUNT_TICK cycles after the exit.
- `blink`:
  - Constant 1 in RUN.
  - In SET, toggles every BLINK_HALF cycles, starting at 1 on SET entry.
  - Restarts at 1 on every edit or cursor move, so the field stays visible while being adjusted.

## Timing
- Reset values:
  - All fields 0.
  - State RUN; `cursor` 000; `blink` 1.
  - Prescaler, repeat and blink counters 0; edge registers 0.
- Reset is asynchronous: mid-edit, all state is discarded immediately.
- All outputs are registered.
- Input sampled at cycle n: field, cursor or state change is visible at n+1.
- Carry chain updates all affected fields in one cycle. Example: 23:59:59.99 → 00:00:00.00 in one tick.
- Held inc beginning at edge cycle n: steps visible at n+1, n+1+REPEAT_DELAY, then +REPEAT_RATE each.

## Structure
- Package `watch_pkg`:
  - FSM state encoding.
  - One-hot cursor constants CUR_SEC=3'b001, CUR_MIN=3'b010, CUR_HOUR=3'b100.
- Sub-module `wrap_counter`:
  - Parameter MAX.
  - Inputs inc, dec, clr. Outputs value, carry_out.
  - Instantiated once per field.
- FSM, prescaler, repeat timer and blink timer live in the top.

## Test plan
Bench parameters: COUNT_TICK=4, REPEAT_DELAY=8, REPEAT_RATE=2, BLINK_HALF=6.
- Release reset and run 4×100 cycles → `sec`=1, `msec`=0. Preload 23:59:59.99 plus one tick → 00:00:00.00.
- `set_sw`=1, then a single `btn_dec` pulse at sec=0 → `sec`=59, `min` unchanged, `cursor`=001.
- Three `btn_sel` edges → cursor 010, 100, 001. `btn_inc` held 20 cycles on min=58 → steps at +1, +9, +11, +13, +15, +17, +19: min=58→5 (wraps, no hour carry).
- `btn_inc` and `btn_dec` both held → no change. `btn_sel` edge with a simultaneous `btn_inc` edge → cursor moves, field unchanged.
- Exit SET at time 12:34:56 → `msec`=0, first `msec` increment 4 cycles later. `blink` toggles every 6 cycles in SET and is 1 in RUN.
- Assert reset mid-repeat → all outputs at their reset values in the same cycle; no steps after release.
